vip_axi4s_traffic_gen: RTL and testbench

//  Synthesizable AXI4-Stream master traffic generator. Implements in hardware the stream modes used by the
//  axi4s agent: TDATA counter/random/custom, TID counter/random and TSTRB all/random. Sits in loopback and FPGA

---
 rtl/vip_axi4s_traffic_gen.sv | 164 ++++++++++++++++
 tb/tb_vip_axi4s_traffic_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_axi4s_traffic_gen.sv
// AXI4-Stream master traffic generator: sends a configured number of fixed-length packets
// with counter, LFSR-random or custom payload, for loopback and FPGA test harnesses.
module vip_axi4s_traffic_gen #(
  parameter int          TDATA_WIDTH_P = 64,
  parameter int          TSTRB_WIDTH_P = TDATA_WIDTH_P / 8,
  parameter int          TID_WIDTH_P   = 4,
  parameter int          TDEST_WIDTH_P = 4,
  parameter int          TUSER_WIDTH_P = 8,
  parameter int          LEN_WIDTH_P   = 16,
  parameter logic [31:0] LFSR_SEED_P   = 32'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               cfg_tdata_mode,
  input  logic                     cfg_tid_mode,
  input  logic                     cfg_tstrb_mode,
  input  logic [TDATA_WIDTH_P-1:0] cfg_custom_tdata,
  input  logic [TDEST_WIDTH_P-1:0] cfg_tdest,
  input  logic [LEN_WIDTH_P-1:0]   cfg_packet_length,
  input  logic [LEN_WIDTH_P-1:0]   cfg_nr_of_packets,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_WIDTH_P-1:0]   packets_sent,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH_P-1:0] m_tdata,
  output logic [TSTRB_WIDTH_P-1:0] m_tstrb,
  output logic [TSTRB_WIDTH_P-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TID_WIDTH_P-1:0]   m_tid,
  output logic [TDEST_WIDTH_P-1:0] m_tdest,
  output logic [TUSER_WIDTH_P-1:0] m_tuser
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam int REP = (TDATA_WIDTH_P + 31) / 32;

  state_t                   state;
  logic [1:0]               data_mode_q;
  logic                     tid_mode_q;
  logic                     tstrb_mode_q;
  logic [TDATA_WIDTH_P-1:0] custom_q;
  logic [TDEST_WIDTH_P-1:0] tdest_q;
  logic [LEN_WIDTH_P-1:0]   len_q;
  logic [LEN_WIDTH_P-1:0]   nr_q;
  logic                     stop_pending;
  logic [LEN_WIDTH_P-1:0]   beat_cnt;
  logic [TDATA_WIDTH_P-1:0] data_cnt;
  logic [31:0]              lfsr;
  logic [31:0]              lfsr_next;
  logic [TID_WIDTH_P-1:0]   tid_q;
  logic [LEN_WIDTH_P-1:0]   pkts_next;
  logic [REP*32-1:0]        lfsr_rep;
  logic                     accept;
  logic                     last_beat;

  assign accept    = m_tvalid & m_tready;
  assign last_beat = (beat_cnt == len_q);
  assign pkts_next = packets_sent + 1'b1;
  assign lfsr_rep  = {REP{lfsr}};

  // Galois form of x^32+x^22+x^2+x+1
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

  // Counters restart at every start so runs are repeatable; the LFSR only restarts on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      data_mode_q  <= '0;
      tid_mode_q   <= 1'b0;
      tstrb_mode_q <= 1'b0;
      custom_q     <= '0;
      tdest_q      <= '0;
      len_q        <= '0;
      nr_q         <= '0;
      stop_pending <= 1'b0;
      beat_cnt     <= '0;
      data_cnt     <= '0;
      lfsr         <= LFSR_SEED_P;
      tid_q        <= '0;
      packets_sent <= '0;
      m_tvalid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_mode_q  <= cfg_tdata_mode;
            tid_mode_q   <= cfg_tid_mode;
            tstrb_mode_q <= cfg_tstrb_mode;
            custom_q     <= cfg_custom_tdata;
            tdest_q      <= cfg_tdest;
            len_q        <= cfg_packet_length;
            nr_q         <= cfg_nr_of_packets;
            stop_pending <= 1'b0;
            beat_cnt     <= '0;
            data_cnt     <= '0;
            tid_q        <= cfg_tid_mode ? lfsr[TID_WIDTH_P-1:0] : '0;
            packets_sent <= '0;
            m_tvalid     <= 1'b1;
            busy         <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (stop) stop_pending <= 1'b1;
          if (accept) begin
            data_cnt <= data_cnt + 1'b1;
            lfsr     <= lfsr_next;
            if (last_beat) begin
              beat_cnt     <= '0;
              packets_sent <= pkts_next;
              if (stop || stop_pending || (nr_q != '0 && pkts_next == nr_q)) begin
                m_tvalid <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end else begin
                tid_q <= tid_mode_q ? lfsr_next[TID_WIDTH_P-1:0] : tid_q + 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          stop_pending <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload is a pure function of registers, forced to zero whenever no beat is offered.
  always_comb begin
    m_tdata = '0;
    m_tstrb = '0;
    m_tkeep = '0;
    m_tlast = 1'b0;
    m_tid   = '0;
    m_tdest = '0;
    m_tuser = '0;
    if (m_tvalid) begin
      case (data_mode_q)
        2'd1:    m_tdata = lfsr_rep[TDATA_WIDTH_P-1:0];
        2'd2:    m_tdata = custom_q;
        default: m_tdata = data_cnt;
      endcase
      m_tstrb = tstrb_mode_q ? lfsr[TSTRB_WIDTH_P-1:0] : '1;
      m_tkeep = '1;
      m_tlast = last_beat;
      m_tid   = tid_q;
      m_tdest = tdest_q;
      m_tuser = packets_sent[TUSER_WIDTH_P-1:0];
    end
  end

endmodule

// File: tb/tb_vip_axi4s_traffic_gen.sv
// Scoreboard bench for vip_axi4s_traffic_gen: a reference model queues the expected beats of
// each run and a negedge monitor checks every offered beat, the done pulse and packets_sent.
module tb_vip_axi4s_traffic_gen;

  localparam logic [31:0] SEED = 32'hACE1;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cfg_tdata_mode;
  logic        cfg_tid_mode;
  logic        cfg_tstrb_mode;
  logic [63:0] cfg_custom_tdata;
  logic [3:0]  cfg_tdest;
  logic [15:0] cfg_packet_length;
  logic [15:0] cfg_nr_of_packets;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [15:0] packets_sent;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic [1:0]  m_tid;
  logic [3:0]  m_tdest;
  logic [7:0]  m_tuser;

  vip_axi4s_traffic_gen #(
    .TDATA_WIDTH_P(64), .TSTRB_WIDTH_P(8), .TID_WIDTH_P(2), .TDEST_WIDTH_P(4),
    .TUSER_WIDTH_P(8), .LEN_WIDTH_P(16), .LFSR_SEED_P(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_tdata_mode(cfg_tdata_mode), .cfg_tid_mode(cfg_tid_mode), .cfg_tstrb_mode(cfg_tstrb_mode),
    .cfg_custom_tdata(cfg_custom_tdata), .cfg_tdest(cfg_tdest),
    .cfg_packet_length(cfg_packet_length), .cfg_nr_of_packets(cfg_nr_of_packets),
    .start(start), .stop(stop), .busy(busy), .done(done), .packets_sent(packets_sent),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [1:0]  id;
    logic [7:0]  user;
    logic [3:0]  dest;
  } beat_t;

  beat_t       expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          lastBeatCyc = 0;
  int          doneCount = 0;
  int          expPacketsSent = 0;
  bit          randomReady = 0;
  logic [31:0] modelLfsr = SEED;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lfsrStep(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the beat sequence is independent of stalls since the LFSR steps per accepted beat.
  task automatic pushRun(input logic [1:0] dmode, input logic tidm, input logic strbm,
                         input logic [63:0] custom, input logic [3:0] dest,
                         input int len, input int npk);
    logic [63:0] cnt;
    logic [1:0]  id;
    beat_t       b;
    cnt = '0;
    for (int p = 0; p < npk; p++) begin
      id = tidm ? modelLfsr[1:0] : p[1:0];
      for (int k = 0; k <= len; k++) begin
        b.data = (dmode == 2'd2) ? custom : (dmode == 2'd1) ? {modelLfsr, modelLfsr} : cnt;
        b.strb = strbm ? modelLfsr[7:0] : 8'hFF;
        b.last = (k == len);
        b.id   = id;
        b.user = p[7:0];
        b.dest = dest;
        expQ.push_back(b);
        cnt       = cnt + 1;
        modelLfsr = lfsrStep(modelLfsr);
      end
    end
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Every offered beat must equal the queue head, whether stalled or accepted.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_tvalid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = expQ[0];
          checkOutput("tdata", m_tdata, b.data);
          checkOutput("tstrb", 64'(m_tstrb), 64'(b.strb));
          checkOutput("tkeep", 64'(m_tkeep), 64'hFF);
          checkOutput("tlast", 64'(m_tlast), 64'(b.last));
          checkOutput("tid", 64'(m_tid), 64'(b.id));
          checkOutput("tuser", 64'(m_tuser), 64'(b.user));
          checkOutput("tdest", 64'(m_tdest), 64'(b.dest));
          if (m_tready) begin
            void'(expQ.pop_front());
            lastBeatCyc = cyc;
          end
        end
      end
      if (done && rst_n) begin
        checkOutput("done_after_last_beat", 64'(cyc - lastBeatCyc), 64'd1);
        checkOutput("queue_empty_at_done", 64'(expQ.size()), 64'd0);
        checkOutput("packets_sent", 64'(packets_sent), 64'(expPacketsSent));
        doneCount++;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] dmode, input logic tidm, input logic strbm,
                               input logic [63:0] custom, input logic [3:0] dest,
                               input int len, input int nr, input int expPkts, input int stopLeft);
    int t;
    int prevDone;
    cfg_tdata_mode    = dmode;
    cfg_tid_mode      = tidm;
    cfg_tstrb_mode    = strbm;
    cfg_custom_tdata  = custom;
    cfg_tdest         = dest;
    cfg_packet_length = 16'(len);
    cfg_nr_of_packets = 16'(nr);
    expPacketsSent    = expPkts;
    pushRun(dmode, tidm, strbm, custom, dest, len, expPkts);
    prevDone = doneCount;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("tvalid_after_start", 64'(m_tvalid), 64'd1);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    cfg_tdata_mode    = ~dmode;
    cfg_custom_tdata  = ~custom;
    cfg_tdest         = ~dest;
    cfg_packet_length = 16'(len + 1);
    cfg_nr_of_packets = 16'(nr + 1);
    cfg_tid_mode      = ~tidm;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (stopLeft >= 0) begin
      t = 0;
      while (expQ.size() > stopLeft && t < 2000) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
    end
    t = 0;
    while (doneCount == prevDone && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (doneCount == prevDone) checkOutput("done_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("single_done", 64'(doneCount - prevDone), 64'd1);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_done", 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_tdata_mode = '0;
    cfg_tid_mode = 1'b0;
    cfg_tstrb_mode = 1'b0;
    cfg_custom_tdata = '0;
    cfg_tdest = '0;
    cfg_packet_length = '0;
    cfg_nr_of_packets = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_packets_sent", 64'(packets_sent), 64'd0);
    checkOutput("reset_tdata", m_tdata, 64'd0);

    $display("[TB] counter mode, 2 packets of 4 beats");
    applyStimulus(2'd0, 1'b0, 1'b0, 64'd0, 4'h3, 3, 2, 2, -1);
    $display("[TB] same run with random backpressure");
    randomReady = 1;
    applyStimulus(2'd0, 1'b0, 1'b0, 64'd0, 4'h3, 3, 2, 2, -1);
    $display("[TB] random data, tid and strobe");
    applyStimulus(2'd1, 1'b1, 1'b1, 64'd0, 4'h9, 5, 3, 3, -1);
    $display("[TB] endless run ended by stop");
    randomReady = 0;
    applyStimulus(2'd0, 1'b0, 1'b0, 64'd0, 4'h1, 3, 0, 1, 3);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    checkOutput("stop_in_idle_busy", 64'(busy), 64'd0);
    $display("[TB] tid counter wrap, length 0");
    randomReady = 1;
    applyStimulus(2'd0, 1'b0, 1'b0, 64'd0, 4'h5, 0, 5, 5, -1);
    $display("[TB] custom payload");
    applyStimulus(2'd2, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 4'hC, 2, 2, 2, -1);

    $display("[TB] reset mid packet");
    randomReady = 0;
    pushRun(2'd0, 1'b0, 1'b0, 64'd0, 4'h2, 3, 2);
    cfg_tdata_mode = 2'd0;
    cfg_tid_mode = 1'b0;
    cfg_tstrb_mode = 1'b0;
    cfg_tdest = 4'h2;
    cfg_packet_length = 16'd3;
    cfg_nr_of_packets = 16'd2;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("midreset_tdata", m_tdata, 64'd0);
    checkOutput("midreset_tlast", 64'(m_tlast), 64'd0);
    checkOutput("midreset_tkeep", 64'(m_tkeep), 64'd0);
    checkOutput("midreset_tuser", 64'(m_tuser), 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_packets_sent", 64'(packets_sent), 64'd0);
    expQ.delete();
    modelLfsr = SEED;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(2'd1, 1'b0, 1'b1, 64'd0, 4'h7, 3, 2, 2, -1);
    applyStimulus(2'd0, 1'b0, 1'b0, 64'd0, 4'h3, 3, 2, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
